window_extremum_tracker: RTL and testbench

Parametrised windowed min/max tracker for sampled data streams, such as AD samples. It splits time into fixed windows of WINDOW_CYCLES clocks and tracks the minimum, maximum and count of the samples qualified by `wren` in each window. At each window close it publishes those results with a one-cycle valid strobe, then restarts empty. It is the successor of the single-channel minimum finder: it adds configurable width, window length, signedness, a max path, per-window restart, a live view and a software clear.

---
 rtl/window_extremum_tracker.sv | 114 +++++++++++
 tb/tb_window_extremum_tracker.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/window_extremum_tracker.sv
// Windowed min/max/count tracker: publishes each window's extrema and sample
// count with a one-cycle strobe and exposes the running extrema as a live view.
module window_extremum_tracker #(
    parameter int unsigned DATA_W        = 9,
    parameter int unsigned WINDOW_CYCLES = 100_000_000,
    parameter int unsigned CNT_W         = 32,
    parameter bit          SIGNED        = 1'b0
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              clr,
    input  logic              wren,
    input  logic [DATA_W-1:0] data,
    output logic [DATA_W-1:0] win_min,
    output logic [DATA_W-1:0] win_max,
    output logic [CNT_W-1:0]  win_count,
    output logic              win_empty,
    output logic              win_valid,
    output logic [DATA_W-1:0] live_min,
    output logic [DATA_W-1:0] live_max
);
    // Window counter is sized from the window length so it cannot alias when
    // CNT_W is narrower than the window; the sample count still saturates.
    localparam int unsigned       WCNT_W   = $clog2(WINDOW_CYCLES);
    localparam logic [WCNT_W-1:0] WLAST    = WCNT_W'(WINDOW_CYCLES - 1);
    localparam logic [DATA_W-1:0] ONES     = '1;
    localparam logic [DATA_W-1:0] MIN_SENT = SIGNED ? (ONES >> 1) : ONES;
    localparam logic [DATA_W-1:0] MAX_SENT = SIGNED ? ~(ONES >> 1) : '0;

    function automatic logic less(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        return a < b;
    endfunction

    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              last_d;
    logic [DATA_W-1:0] data_q;
    logic              wren_q;
    logic              last_q;
    logic [DATA_W-1:0] run_min_q, run_max_q;
    logic [CNT_W-1:0]  run_cnt_q;
    logic [DATA_W-1:0] min_d, max_d;
    logic [CNT_W-1:0]  cnt_d;
    logic [DATA_W-1:0] win_min_q, win_max_q;
    logic [CNT_W-1:0]  win_count_q;
    logic              win_empty_q;
    logic              win_valid_q;

    always_comb begin
        min_d = run_min_q;
        if (wren_q && less(data_q, run_min_q)) min_d = data_q;
        max_d = run_max_q;
        if (wren_q && less(run_max_q, data_q)) max_d = data_q;
        cnt_d = run_cnt_q;
        if (wren_q && (run_cnt_q != '1)) cnt_d = run_cnt_q + CNT_W'(1);
        last_d = (wcnt_q == WLAST);
        wcnt_d = last_d ? '0 : wcnt_q + WCNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wcnt_q      <= '0;
            data_q      <= '0;
            wren_q      <= 1'b0;
            last_q      <= 1'b0;
            run_min_q   <= MIN_SENT;
            run_max_q   <= MAX_SENT;
            run_cnt_q   <= '0;
            win_min_q   <= MIN_SENT;
            win_max_q   <= MAX_SENT;
            win_count_q <= '0;
            win_empty_q <= 1'b1;
            win_valid_q <= 1'b0;
        end else if (clr) begin
            // Dropping last_q here is what suppresses a publish on a coinciding last cycle.
            wcnt_q      <= '0;
            data_q      <= data;
            wren_q      <= 1'b0;
            last_q      <= 1'b0;
            run_min_q   <= MIN_SENT;
            run_max_q   <= MAX_SENT;
            run_cnt_q   <= '0;
            win_valid_q <= 1'b0;
        end else begin
            wcnt_q      <= wcnt_d;
            data_q      <= data;
            wren_q      <= wren;
            last_q      <= last_d;
            win_valid_q <= last_q;
            if (last_q) begin
                win_min_q   <= min_d;
                win_max_q   <= max_d;
                win_count_q <= cnt_d;
                win_empty_q <= (cnt_d == '0);
                run_min_q   <= MIN_SENT;
                run_max_q   <= MAX_SENT;
                run_cnt_q   <= '0;
            end else begin
                run_min_q <= min_d;
                run_max_q <= max_d;
                run_cnt_q <= cnt_d;
            end
        end
    end

    assign win_min   = win_min_q;
    assign win_max   = win_max_q;
    assign win_count = win_count_q;
    assign win_empty = win_empty_q;
    assign win_valid = win_valid_q;
    assign live_min  = run_min_q;
    assign live_max  = run_max_q;

endmodule

// File: tb/tb_window_extremum_tracker.sv
// Bench for window_extremum_tracker: three instances (unsigned, signed, long
// window) share one stimulus stream and are checked against a sample-list model.
module tb_window_extremum_tracker;
    localparam int NI = 3;

    logic       clk = 1'b0;
    logic       rst, clr, wren;
    logic [8:0] data;

    logic [8:0] wmin [NI];
    logic [8:0] wmax [NI];
    logic [7:0] wcnt [NI];
    logic       wemp [NI];
    logic       wval [NI];
    logic [8:0] lmin [NI];
    logic [8:0] lmax [NI];

    always #5 clk = ~clk;

    window_extremum_tracker #(.DATA_W(9), .WINDOW_CYCLES(8), .CNT_W(8), .SIGNED(1'b0)) u0 (
        .clock(clk), .rst(rst), .clr(clr), .wren(wren), .data(data),
        .win_min(wmin[0]), .win_max(wmax[0]), .win_count(wcnt[0]), .win_empty(wemp[0]),
        .win_valid(wval[0]), .live_min(lmin[0]), .live_max(lmax[0]));

    window_extremum_tracker #(.DATA_W(9), .WINDOW_CYCLES(8), .CNT_W(8), .SIGNED(1'b1)) u1 (
        .clock(clk), .rst(rst), .clr(clr), .wren(wren), .data(data),
        .win_min(wmin[1]), .win_max(wmax[1]), .win_count(wcnt[1]), .win_empty(wemp[1]),
        .win_valid(wval[1]), .live_min(lmin[1]), .live_max(lmax[1]));

    window_extremum_tracker #(.DATA_W(9), .WINDOW_CYCLES(300), .CNT_W(8), .SIGNED(1'b0)) u2 (
        .clock(clk), .rst(rst), .clr(clr), .wren(wren), .data(data),
        .win_min(wmin[2]), .win_max(wmax[2]), .win_count(wcnt[2]), .win_empty(wemp[2]),
        .win_valid(wval[2]), .live_min(lmin[2]), .live_max(lmax[2]));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[u%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    function automatic bit sg(input int k);
        return k == 1;
    endfunction
    function automatic int win_len(input int k);
        return (k == 2) ? 300 : 8;
    endfunction
    function automatic logic [8:0] min_sent(input int k);
        return sg(k) ? 9'h0FF : 9'h1FF;
    endfunction
    function automatic logic [8:0] max_sent(input int k);
        return sg(k) ? 9'h100 : 9'h000;
    endfunction
    function automatic int num(input int k, input logic [8:0] v);
        if (sg(k) && v[8]) return int'(v) - 512;
        return int'(v);
    endfunction

    // Model: samples of the open window kept as a list; each input cycle's
    // result becomes visible one edge after it is registered.
    logic [8:0] samp [NI][$];
    int         pos      [NI];
    bit         rec_last [NI];
    logic [8:0] rec_mn   [NI];
    logic [8:0] rec_mx   [NI];
    int         rec_n    [NI];
    logic [8:0] e_wmin [NI];
    logic [8:0] e_wmax [NI];
    logic [8:0] e_lmin [NI];
    logic [8:0] e_lmax [NI];
    int         e_cnt  [NI];
    bit         e_emp  [NI];
    bit         e_val  [NI];
    bit         model_ok = 1'b0;

    task automatic window_stats(input int k, output logic [8:0] mn, output logic [8:0] mx, output int n);
        mn = min_sent(k);
        mx = max_sent(k);
        n  = samp[k].size();
        for (int i = 0; i < samp[k].size(); i++) begin
            if (num(k, samp[k][i]) < num(k, mn)) mn = samp[k][i];
            if (num(k, samp[k][i]) > num(k, mx)) mx = samp[k][i];
        end
        if (n > 255) n = 255;
    endtask

    task automatic model_step(input int k);
        if (rst || clr) begin
            if (rst) begin
                e_wmin[k] = min_sent(k);
                e_wmax[k] = max_sent(k);
                e_cnt[k]  = 0;
                e_emp[k]  = 1'b1;
            end
            e_val[k]  = 1'b0;
            e_lmin[k] = min_sent(k);
            e_lmax[k] = max_sent(k);
            pos[k]    = 0;
            samp[k].delete();
            rec_last[k] = 1'b0;
            rec_mn[k]   = min_sent(k);
            rec_mx[k]   = max_sent(k);
            rec_n[k]    = 0;
        end else begin
            if (rec_last[k]) begin
                e_wmin[k] = rec_mn[k];
                e_wmax[k] = rec_mx[k];
                e_cnt[k]  = rec_n[k];
                e_emp[k]  = (rec_n[k] == 0);
                e_val[k]  = 1'b1;
                e_lmin[k] = min_sent(k);
                e_lmax[k] = max_sent(k);
            end else begin
                e_val[k]  = 1'b0;
                e_lmin[k] = rec_mn[k];
                e_lmax[k] = rec_mx[k];
            end
            if (wren) samp[k].push_back(data);
            window_stats(k, rec_mn[k], rec_mx[k], rec_n[k]);
            rec_last[k] = (pos[k] == win_len(k) - 1);
            if (rec_last[k]) begin
                samp[k].delete();
                pos[k] = 0;
            end else begin
                pos[k]++;
            end
        end
    endtask

    initial begin
        for (int k = 0; k < NI; k++) pos[k] = 0;
        forever begin
            @(posedge clk);
            for (int k = 0; k < NI; k++) model_step(k);
            if (rst) model_ok = 1'b1;
            #1;
            if (model_ok) begin
                for (int k = 0; k < NI; k++) begin
                    chk("win_valid", k, 32'(wval[k]), 32'(e_val[k]));
                    chk("win_min",   k, 32'(wmin[k]), 32'(e_wmin[k]));
                    chk("win_max",   k, 32'(wmax[k]), 32'(e_wmax[k]));
                    chk("win_count", k, 32'(wcnt[k]), 32'(e_cnt[k]));
                    chk("win_empty", k, 32'(wemp[k]), 32'(e_emp[k]));
                    chk("live_min",  k, 32'(lmin[k]), 32'(e_lmin[k]));
                    chk("live_max",  k, 32'(lmax[k]), 32'(e_lmax[k]));
                end
            end
        end
    end

    task automatic drive(input logic r, input logic c, input logic w, input logic [8:0] d);
        rst  = r;
        clr  = c;
        wren = w;
        data = d;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 9'h000);
    endtask

    int pulses;
    bit got;

    initial begin
        rst = 1'b0; clr = 1'b0; wren = 1'b0; data = '0;
        drive(1'b1, 1'b0, 1'b0, 9'h000);
        drive(1'b1, 1'b0, 1'b0, 9'h000);
        chk("rst_win_min",   0, 32'(wmin[0]), 32'h1FF);
        chk("rst_win_max",   0, 32'(wmax[0]), 32'h000);
        chk("rst_win_empty", 0, 32'(wemp[0]), 32'h1);
        chk("rst_win_valid", 0, 32'(wval[0]), 32'h0);
        chk("rst_win_min",   1, 32'(wmin[1]), 32'h0FF);
        chk("rst_win_max",   1, 32'(wmax[1]), 32'h100);

        // Idle windows: pulses after input cycles 7 and 15.
        pulses = 0;
        for (int i = 0; i < 24; i++) begin
            idle(1);
            if (wval[0]) begin
                pulses++;
                chk("idle_empty", 0, 32'(wemp[0]), 32'h1);
            end
        end
        chk("idle_pulses", 0, 32'(pulses), 32'd2);

        // Basic window, samples at positions 1..4.
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 9'h050);
        drive(1'b0, 1'b0, 1'b1, 9'h010);
        drive(1'b0, 1'b0, 1'b1, 9'h1F0);
        drive(1'b0, 1'b0, 1'b1, 9'h010);
        idle(4);
        chk("basic_valid", 0, 32'(wval[0]), 32'h1);
        chk("basic_min",   0, 32'(wmin[0]), 32'h010);
        chk("basic_max",   0, 32'(wmax[0]), 32'h1F0);
        chk("basic_count", 0, 32'(wcnt[0]), 32'd4);
        chk("basic_empty", 0, 32'(wemp[0]), 32'h0);
        chk("basic_min_s", 1, 32'(wmin[1]), 32'h1F0);
        chk("basic_max_s", 1, 32'(wmax[1]), 32'h050);
        idle(1);
        chk("basic_live_min", 0, 32'(lmin[0]), 32'h1FF);
        chk("basic_live_max", 0, 32'(lmax[0]), 32'h000);

        // Boundary: last cycle of one window, first cycle of the next.
        idle(5);
        drive(1'b0, 1'b0, 1'b1, 9'h005);
        drive(1'b0, 1'b0, 1'b1, 9'h1FE);
        chk("bnd_valid", 0, 32'(wval[0]), 32'h1);
        chk("bnd_min",   0, 32'(wmin[0]), 32'h005);
        chk("bnd_max",   0, 32'(wmax[0]), 32'h005);
        chk("bnd_count", 0, 32'(wcnt[0]), 32'd1);
        idle(8);
        chk("bnd2_valid", 0, 32'(wval[0]), 32'h1);
        chk("bnd2_min",   0, 32'(wmin[0]), 32'h1FE);
        chk("bnd2_max",   0, 32'(wmax[0]), 32'h1FE);
        chk("bnd2_count", 0, 32'(wcnt[0]), 32'd1);

        // Signed ordering.
        drive(1'b0, 1'b0, 1'b1, 9'h1FF);
        drive(1'b0, 1'b0, 1'b1, 9'h002);
        drive(1'b0, 1'b0, 1'b1, 9'h100);
        idle(5);
        chk("sgn_valid", 1, 32'(wval[1]), 32'h1);
        chk("sgn_min",   1, 32'(wmin[1]), 32'h100);
        chk("sgn_max",   1, 32'(wmax[1]), 32'h002);
        chk("uns_min",   0, 32'(wmin[0]), 32'h002);
        chk("uns_max",   0, 32'(wmax[0]), 32'h1FF);

        // Clear on the last cycle of a window with wren high.
        idle(1);
        drive(1'b0, 1'b0, 1'b1, 9'h033);
        idle(4);
        drive(1'b0, 1'b1, 1'b1, 9'h001);
        chk("clr_no_valid", 0, 32'(wval[0]), 32'h0);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, 1'(i == 3), 9'h077);
            if (wval[0]) pulses++;
        end
        chk("clr_pulses", 0, 32'(pulses), 32'd0);
        chk("clr_keep_min", 0, 32'(wmin[0]), 32'h002);
        chk("clr_keep_cnt", 0, 32'(wcnt[0]), 32'd3);
        idle(1);
        chk("clr_valid", 0, 32'(wval[0]), 32'h1);
        chk("clr_min",   0, 32'(wmin[0]), 32'h077);
        chk("clr_max",   0, 32'(wmax[0]), 32'h077);
        chk("clr_count", 0, 32'(wcnt[0]), 32'd1);

        // Saturation: a full 300-cycle window of samples.
        drive(1'b0, 1'b1, 1'b0, 9'h000);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b0, 1'b1, 9'(i * 37));
        got = 1'b0;
        for (int i = 0; i < 5 && !got; i++) begin
            idle(1);
            if (wval[2]) got = 1'b1;
        end
        chk("sat_pulse_seen", 2, 32'(got), 32'h1);
        chk("sat_count", 2, 32'(wcnt[2]), 32'hFF);
        chk("sat_empty", 2, 32'(wemp[2]), 32'h0);

        idle(10);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
